// File: rtl/salida_pico_ports.sv
`default_nettype none
// ============================================================================
//  Module   : salida_pico_ports
//  Purpose  : Output-port register bank sitting on the PicoBlaze output bus
//             of the RTC/timer design. Each qualified write strobe decodes
//             the processor port ID against a window of twelve consecutive
//             IDs starting at BASE_ADDR. A hit latches the 8-bit out_port
//             data into the matching holding register. The holding registers
//             directly drive the display / RTC-interface logic.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BASE_ADDR  port ID of register offset 0 (bank spans BASE_ADDR..+11)
//
//  Ports
//    clk        in   1   system clock, rising edge
//    reset      in   1   asynchronous reset, active low
//    pico_out   in   8   PicoBlaze out_port data
//    id_port    in   8   PicoBlaze port_id
//    write_s    in   1   PicoBlaze write_strobe, active high
//    seg        out  8   offset  0  RTC seconds
//    min        out  8   offset  1  RTC minutes
//    hora       out  8   offset  2  RTC hours
//    dia        out  8   offset  3  RTC day
//    mes        out  8   offset  4  RTC month
//    year       out  8   offset  5  RTC year
//    seg_tim    out  8   offset  6  timer seconds
//    min_tim    out  8   offset  7  timer minutes
//    hora_tim   out  8   offset  8  timer hours
//    swt        out  8   offset  9  switch / mode code
//    flecha     out  8   offset 10  arrow / cursor code
//    operacion  out  8   offset 11  operation code
//    wr_pulse   out 12   one-cycle write indication per register
//                        (present only with SALIDA_PICO_STROBE_EN)
//
//  Build option
//    SALIDA_PICO_STROBE_EN  adds the wr_pulse output and its register. When
//                           undefined the port and its logic are absent.
// ============================================================================

module salida_pico_ports #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pico_out,
  input  logic [7:0]  id_port,
  input  logic        write_s,
  output logic [7:0]  seg,
  output logic [7:0]  min,
  output logic [7:0]  hora,
  output logic [7:0]  dia,
  output logic [7:0]  mes,
  output logic [7:0]  year,
  output logic [7:0]  seg_tim,
  output logic [7:0]  min_tim,
  output logic [7:0]  hora_tim,
  output logic [7:0]  swt,
  output logic [7:0]  flecha,
  output logic [7:0]  operacion
`ifdef SALIDA_PICO_STROBE_EN
  ,
  output logic [11:0] wr_pulse
`endif
);

  localparam int         c_num_regs = 12;
  localparam logic [7:0] c_num_regs_b = 8'd12;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  // The offset is taken modulo 256 so an ID below BASE_ADDR wraps to a large
  // value and falls outside the window; a single unsigned compare then covers
  // both "below base" and "above top".
  logic [7:0]            w_offset;
  logic                  w_in_range;
  logic                  w_hit;
  logic [c_num_regs-1:0] w_sel;

  assign w_offset   = id_port - BASE_ADDR;
  assign w_in_range = (w_offset < c_num_regs_b);
  assign w_hit      = write_s & w_in_range;

  // One-hot register select. At most one bit is set because w_offset has a
  // single value per cycle.
  for (genvar k = 0; k < c_num_regs; k++) begin : g_sel
    localparam logic [7:0] c_idx = 8'(k);
    assign w_sel[k] = w_hit & (w_offset == c_idx);
  end

  // --------------------------------------------------------------------------
  // Holding registers
  // --------------------------------------------------------------------------
  // Data is stored verbatim; the firmware owns any BCD or range meaning.
  logic [7:0] r_bank [c_num_regs];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_bank[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < c_num_regs; i++) begin
        if (w_sel[i]) begin
          r_bank[i] <= pico_out;
        end
      end
    end
  end

  // Outputs come straight from the flops; no input reaches an output
  // without passing through a register.
  assign seg       = r_bank[0];
  assign min       = r_bank[1];
  assign hora      = r_bank[2];
  assign dia       = r_bank[3];
  assign mes       = r_bank[4];
  assign year      = r_bank[5];
  assign seg_tim   = r_bank[6];
  assign min_tim   = r_bank[7];
  assign hora_tim  = r_bank[8];
  assign swt       = r_bank[9];
  assign flecha    = r_bank[10];
  assign operacion = r_bank[11];

  // --------------------------------------------------------------------------
  // Optional write indication
  // --------------------------------------------------------------------------
`ifdef SALIDA_PICO_STROBE_EN
  // Registering the select gives a pulse aligned with the cycle in which the
  // new register value is first visible. Back-to-back writes to the same
  // register keep the bit high for the same number of cycles.
  logic [c_num_regs-1:0] r_wr_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_sel;
    end
  end

  assign wr_pulse = r_wr_pulse;
`else
  // Without the write indication the decode feeds only the register bank.
`endif

endmodule

`default_nettype wire

// File: tb/tb_salida_pico_ports.sv
`default_nettype none
// ============================================================================
//  Module   : tb_salida_pico_ports
//  Purpose  : Directed, self-checking bench for salida_pico_ports. A small
//             reference array holds the value each register should contain.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_salida_pico_ports;

  localparam logic [7:0] TB_BASE = 8'h00;

  logic        clk;
  logic        reset;
  logic [7:0]  pico_out;
  logic [7:0]  id_port;
  logic        write_s;
  logic [7:0]  seg, min, hora, dia, mes, year;
  logic [7:0]  seg_tim, min_tim, hora_tim, swt, flecha, operacion;
`ifdef SALIDA_PICO_STROBE_EN
  logic [11:0] wr_pulse;
`endif

  salida_pico_ports #(.BASE_ADDR(TB_BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .pico_out  (pico_out),
    .id_port   (id_port),
    .write_s   (write_s),
    .seg       (seg),
    .min       (min),
    .hora      (hora),
    .dia       (dia),
    .mes       (mes),
    .year      (year),
    .seg_tim   (seg_tim),
    .min_tim   (min_tim),
    .hora_tim  (hora_tim),
    .swt       (swt),
    .flecha    (flecha),
    .operacion (operacion)
`ifdef SALIDA_PICO_STROBE_EN
    ,
    .wr_pulse  (wr_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs [12];
  assign obs[0]  = seg;
  assign obs[1]  = min;
  assign obs[2]  = hora;
  assign obs[3]  = dia;
  assign obs[4]  = mes;
  assign obs[5]  = year;
  assign obs[6]  = seg_tim;
  assign obs[7]  = min_tim;
  assign obs[8]  = hora_tim;
  assign obs[9]  = swt;
  assign obs[10] = flecha;
  assign obs[11] = operacion;

  logic [7:0] exp_q [12];
  int tests;
  int fails;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s[%0d]", tag, k), {24'h0, obs[k]}, {24'h0, exp_q[k]});
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 12; k++) exp_q[k] = 8'h00;
  endtask

  // Record the effect of one strobed write in the reference array.
  task automatic model_write(input logic [7:0] id, input logic [7:0] data);
    logic [7:0] off;
    off = id - TB_BASE;
    if (off < 8'd12) exp_q[off] = data;
  endtask

  // One-cycle write: inputs set after a falling edge, captured on the
  // following rising edge, strobe dropped at the next falling edge.
  task automatic do_write(input logic [7:0] id, input logic [7:0] data);
    @(negedge clk);
    id_port  = id;
    pico_out = data;
    write_s  = 1'b1;
    @(negedge clk);
    write_s  = 1'b0;
    model_write(id, data);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_model();

    // Reset asserted with a live write pending: nothing may load.
    reset    = 1'b0;
    pico_out = 8'd12;
    id_port  = 8'd0;
    write_s  = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset_hold");

    // Release reset with the write still active: seg loads on the next edge.
    reset = 1'b1;
    @(negedge clk);
    write_s = 1'b0;
    exp_q[0] = 8'd12;
    check_all("reset_release");

    // Sequential fill 12..1 into offsets 0..11.
    for (int i = 0; i < 12; i++) begin
      do_write(8'(i), 8'(12 - i));
    end
    check("fill_seg", {24'h0, seg}, 32'd12);
    check("fill_operacion", {24'h0, operacion}, 32'd1);
    check_all("fill");

    // Out-of-range IDs, including the top of the 8-bit space.
    do_write(8'd12, 8'h00);
    check_all("oor_12");
    do_write(8'hFF, 8'hFF);
    check_all("oor_ff");

    // Single overwrite.
    do_write(8'd0, 8'd9);
    check("ovw_seg", {24'h0, seg}, 32'd9);
    check_all("overwrite");

    // Inputs moving with the strobe low.
    write_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id_port  = 8'(i * 3);
      pico_out = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    check_all("gated");

    // Strobe held for three edges on offset 3: last value wins.
    @(negedge clk);
    id_port  = 8'd3;
    pico_out = 8'h31;
    write_s  = 1'b1;
    @(negedge clk);
    check("burst1_dia", {24'h0, dia}, 32'h31);
`ifdef SALIDA_PICO_STROBE_EN
    check("burst1_pulse", {20'h0, wr_pulse}, 32'h008);
`endif
    pico_out = 8'h32;
    @(negedge clk);
    pico_out = 8'h33;
`ifdef SALIDA_PICO_STROBE_EN
    check("burst2_pulse", {20'h0, wr_pulse}, 32'h008);
`endif
    @(negedge clk);
    write_s = 1'b0;
    exp_q[3] = 8'h33;
    check_all("burst");

`ifdef SALIDA_PICO_STROBE_EN
    // Single write to offset 5 gives one pulse cycle on bit 5.
    @(negedge clk);
    check("pulse_idle", {20'h0, wr_pulse}, 32'h000);
    do_write(8'd5, 8'h55);
    check("pulse_id5", {20'h0, wr_pulse}, 32'h020);
    @(negedge clk);
    check("pulse_id5_off", {20'h0, wr_pulse}, 32'h000);
`endif

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    check_all("async_reset");
`ifdef SALIDA_PICO_STROBE_EN
    check("async_pulse", {20'h0, wr_pulse}, 32'h000);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
